spu_mem_writeback: RTL and testbench

Consumer side of the SPU Execute stage. Accepts one execute result per handshake (ALU result, store data, destination register, branch outcome) and performs the local-store access. It then drives the 128-bit register-file write port and resolves branch redirects. Sits between Execute and the register file / PC logic; it is the only writer of the register file.

---
 rtl/spu_mem_writeback.sv | 174 +++++++++++++++++
 tb/tb_spu_mem_writeback.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_mem_writeback.sv
// spu_mem_writeback
//   Consumer side of the SPU Execute stage. Accepts one execute result per
//   ex_valid/ex_ready handshake, performs the local-store access for loads
//   and stores, drives the register-file write port (sole writer), and
//   issues branch redirects.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   ex_*            execute result handshake and fields (captured at accept)
//   ls_*            local-store request/response (ls_rdata valid with ls_ack)
//   wb_en/addr/data register-file write port
//   pc_redirect     one-cycle redirect pulse, target on pc_target
//   ls_error        one-cycle local-store timeout pulse
//
// Optional feature macro: LS_TIMEOUT_EN
//   Defined:   MEM_WAIT gives up after LS_TIMEOUT cycles without ls_ack,
//              pulses ls_error and skips the writeback.
//   Undefined: MEM_WAIT waits indefinitely and ls_error stays 0.
module spu_mem_writeback #(
    parameter int PC_bitSize = 11,
    parameter int DATA_W     = 128,
    parameter int REG_AW     = 7,
    parameter int LS_AW      = 11,
    parameter int LS_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_AW-1:0]     ex_dest_reg,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_branch,
    input  logic                  ex_zero,
    input  logic [PC_bitSize:0]   ex_jump_pc,
    output logic                  ls_req,
    output logic                  ls_we,
    output logic [LS_AW-1:0]      ls_addr,
    output logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W-1:0]     ls_rdata,
    input  logic                  ls_ack,
    output logic                  wb_en,
    output logic [REG_AW-1:0]     wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  pc_redirect,
    output logic [PC_bitSize:0]   pc_target,
    output logic                  ls_error
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, WRITEBACK} state_t;

    state_t              state;
    logic                is_load;   // remembers whether MEM_WAIT ends in a writeback
    logic [REG_AW-1:0]   dest_q;
    logic                accept;
    logic                do_store;
    logic                do_load;

    assign accept   = ex_valid & ex_ready;
    // A store wins when both memory flags are set; the load is dropped.
    assign do_store = ex_mem_write;
    assign do_load  = ex_mem_read & ~ex_mem_write;

`ifdef LS_TIMEOUT_EN
    localparam int CNT_W = $clog2(LS_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    // Counter holds the number of waiting cycles already elapsed, so the
    // last permitted cycle is LS_TIMEOUT-1.
    assign timed_out = (wait_cnt == CNT_W'(LS_TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (LS_TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ex_ready    <= 1'b1;
            ls_req      <= 1'b0;
            ls_we       <= 1'b0;
            ls_addr     <= '0;
            ls_wdata    <= '0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            pc_redirect <= 1'b0;
            pc_target   <= '0;
            ls_error    <= 1'b0;
            is_load     <= 1'b0;
            dest_q      <= '0;
`ifdef LS_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            // Pulse outputs default low each cycle.
            pc_redirect <= 1'b0;
            ls_error    <= 1'b0;
            wb_en       <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        // Redirect is resolved at accept, independent of
                        // whichever memory/writeback path the op takes.
                        if (ex_branch && ex_zero) begin
                            pc_redirect <= 1'b1;
                            pc_target   <= ex_jump_pc;
                        end
                        if (do_store || do_load) begin
                            state    <= MEM_WAIT;
                            ex_ready <= 1'b0;
                            ls_req   <= 1'b1;
                            ls_we    <= do_store;
                            ls_addr  <= ex_alu_result[LS_AW+3:4];
                            ls_wdata <= ex_store_data;
                            is_load  <= do_load;
                            dest_q   <= ex_dest_reg;
`ifdef LS_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else if (ex_reg_write) begin
                            state    <= WRITEBACK;
                            ex_ready <= 1'b0;
                            wb_en    <= 1'b1;
                            wb_addr  <= ex_dest_reg;
                            wb_data  <= ex_alu_result;
                        end
                    end
                end

                MEM_WAIT: begin
                    if (ls_req && ls_ack) begin
                        ls_req <= 1'b0;
                        if (is_load) begin
                            state   <= WRITEBACK;
                            wb_en   <= 1'b1;
                            wb_addr <= dest_q;
                            wb_data <= ls_rdata;
                        end else begin
                            state    <= IDLE;
                            ex_ready <= 1'b1;
                        end
                    end
`ifdef LS_TIMEOUT_EN
                    else if (timed_out) begin
                        ls_req   <= 1'b0;
                        ls_error <= 1'b1;
                        state    <= IDLE;
                        ex_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                WRITEBACK: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                    ls_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spu_mem_writeback.sv
// tb_spu_mem_writeback
//   Randomized self-checking bench for spu_mem_writeback. Each operation is
//   described by its fields and an ack delay; the expected cycle-by-cycle
//   outputs after accept are derived from the operation kind and that delay.
module tb_spu_mem_writeback;

    localparam int DW  = 128;
    localparam int AW  = 7;
    localparam int LAW = 11;
`ifdef LS_TIMEOUT_EN
    localparam int TO   = 4;
    localparam bit TOEN = 1'b1;
`else
    localparam int TO   = 64;
    localparam bit TOEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic            ex_ready;
    logic [DW-1:0]   ex_alu_result;
    logic [DW-1:0]   ex_store_data;
    logic [AW-1:0]   ex_dest_reg;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;
    logic            ex_zero;
    logic [11:0]     ex_jump_pc;
    logic            ls_req;
    logic            ls_we;
    logic [LAW-1:0]  ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic [DW-1:0]   ls_rdata;
    logic            ls_ack;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic            pc_redirect;
    logic [11:0]     pc_target;
    logic            ls_error;

    spu_mem_writeback #(
        .PC_bitSize(11), .DATA_W(DW), .REG_AW(AW), .LS_AW(LAW), .LS_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_jump_pc(ex_jump_pc),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .ls_error(ls_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Random execute fields; ex_valid may be high, which must be ignored
    // while the block is busy.
    task automatic drive_junk();
        ex_valid      = 1'($urandom_range(0, 1));
        ex_alu_result = rnd128();
        ex_store_data = rnd128();
        ex_dest_reg   = 7'($urandom);
        ex_reg_write  = 1'($urandom);
        ex_mem_read   = 1'($urandom);
        ex_mem_write  = 1'($urandom);
        ex_branch     = 1'($urandom);
        ex_zero       = 1'($urandom);
        ex_jump_pc    = 12'($urandom);
    endtask

    // Present one op while the block is idle, then follow it until the block
    // is expected to be ready again. d = cycles of ls_ack low before the ack.
    task automatic run_op(input logic [127:0] alu, input logic [127:0] sd, input logic [6:0] dest,
                          input logic rw, input logic mr, input logic mw,
                          input logic br, input logic z, input logic [11:0] jpc,
                          input int d, input logic [127:0] rdata);
        bit is_store, is_load, mem, redir, tmo;
        bit e_req, e_wb, e_ready, e_err, e_redir;
        int k_end;
        is_store = mw;
        is_load  = mr && !mw;
        mem      = is_store || is_load;
        redir    = br && z;
        tmo      = TOEN && mem && (d >= TO);
        if (mem && tmo)   k_end = TO + 1;
        else if (is_store) k_end = d + 2;
        else if (is_load)  k_end = d + 3;
        else if (rw)       k_end = 2;
        else               k_end = 1;

        check_val("ready_before_accept", 128'(ex_ready), 128'(1));
        ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_dest_reg = dest;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
        ex_branch = br; ex_zero = z; ex_jump_pc = jpc;
        ls_ack = 1'($urandom);        // block is idle: any ack here is spurious
        ls_rdata = rnd128();

        for (int k = 1; k <= k_end; k++) begin
            tick();
            e_req   = mem && (tmo ? (k <= TO) : (k <= d + 1));
            e_wb    = (is_load && !tmo && k == d + 2) || (!mem && rw && k == 1);
            e_ready = (k == k_end);
            e_err   = tmo && (k == TO + 1);
            e_redir = redir && (k == 1);
            check_val("ex_ready", 128'(ex_ready), 128'(e_ready));
            check_val("ls_req", 128'(ls_req), 128'(e_req));
            check_val("wb_en", 128'(wb_en), 128'(e_wb));
            check_val("pc_redirect", 128'(pc_redirect), 128'(e_redir));
            check_val("ls_error", 128'(ls_error), 128'(e_err));
            if (e_req) begin
                check_val("ls_we", 128'(ls_we), 128'(is_store));
                check_val("ls_addr", 128'(ls_addr), 128'(alu[LAW+3:4]));
                if (is_store) check_val("ls_wdata", ls_wdata, sd);
            end
            if (e_wb) begin
                check_val("wb_addr", 128'(wb_addr), 128'(dest));
                check_val("wb_data", wb_data, is_load ? rdata : alu);
            end
            if (e_redir) check_val("pc_target", 128'(pc_target), 128'(jpc));
            if (k < k_end) begin
                drive_junk();
                if (e_req) begin
                    ls_ack   = !tmo && (k == d + 1);
                    ls_rdata = ls_ack ? rdata : rnd128();
                end else begin
                    ls_ack   = 1'($urandom);
                    ls_rdata = rnd128();
                end
            end
        end
    endtask

    task automatic idle_cycle();
        ex_valid = 1'b0;
        ls_ack   = 1'($urandom);
        ls_rdata = rnd128();
        tick();
        check_val("idle_ready", 128'(ex_ready), 128'(1));
        check_val("idle_ls_req", 128'(ls_req), 128'(0));
        check_val("idle_wb_en", 128'(wb_en), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_junk();
        ex_valid = 1'b0;
        ls_ack = 1'b0;
        ls_rdata = '0;
        tick(); tick();
        check_val("rst_ready", 128'(ex_ready), 128'(1));
        check_val("rst_ls_req", 128'(ls_req), 128'(0));
        check_val("rst_ls_we", 128'(ls_we), 128'(0));
        check_val("rst_ls_addr", 128'(ls_addr), 128'(0));
        check_val("rst_ls_wdata", ls_wdata, 128'(0));
        check_val("rst_wb_en", 128'(wb_en), 128'(0));
        check_val("rst_wb_addr", 128'(wb_addr), 128'(0));
        check_val("rst_wb_data", wb_data, 128'(0));
        check_val("rst_redirect", 128'(pc_redirect), 128'(0));
        check_val("rst_target", 128'(pc_target), 128'(0));
        check_val("rst_ls_error", 128'(ls_error), 128'(0));
        rst = 1'b0;
        idle_cycle();

        // Directed cases
        run_op({16{8'hA5}}, rnd128(), 7'd5, 1, 0, 0, 0, 0, 12'h0, 0, '0);
        run_op(128'h130, 128'h1234, 7'd3, 1, 0, 1, 0, 0, 12'h0, 3, '0);
        run_op(128'h40, rnd128(), 7'd127, 1, 1, 0, 0, 0, 12'h0, 0, 128'hDEAD_BEEF);
        run_op(rnd128(), rnd128(), 7'd1, 0, 0, 0, 1, 1, 12'h7FC, 0, '0);
        run_op(rnd128(), rnd128(), 7'd1, 0, 0, 0, 1, 0, 12'h7FC, 0, '0);
        run_op(128'h7FF0, 128'hCAFE, 7'd9, 0, 1, 1, 1, 1, 12'h123, 2, 128'h5555);
        if (TOEN) run_op(128'h50, rnd128(), 7'd4, 1, 1, 0, 0, 0, 12'h0, TO, 128'h77);
        idle_cycle();

        // Randomized operation stream, back-to-back or with short gaps
        for (int i = 0; i < 300; i++) begin
            int kind, gap;
            logic rw, mr, mw;
            kind = $urandom_range(0, 4);
            rw = 1'($urandom);
            case (kind)
                0: begin mr = 0; mw = 0; rw = 1; end
                1: begin mr = 0; mw = 0; rw = 0; end
                2: begin mr = 0; mw = 1; end
                3: begin mr = 1; mw = 0; end
                default: begin mr = 1; mw = 1; end
            endcase
            run_op(rnd128(), rnd128(), 7'($urandom), rw, mr, mw,
                   1'($urandom), 1'($urandom), 12'($urandom),
                   $urandom_range(0, 6), rnd128());
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle();
        end

        // Reset while a load waits for its ack
        ex_valid = 1'b1; ex_alu_result = 128'h40; ex_dest_reg = 7'd9;
        ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 0; ex_branch = 0; ex_zero = 0;
        ls_ack = 1'b0;
        tick();
        check_val("rstmid_req_before", 128'(ls_req), 128'(1));
        ex_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rstmid_req", 128'(ls_req), 128'(0));
        check_val("rstmid_wb_en", 128'(wb_en), 128'(0));
        check_val("rstmid_ready", 128'(ex_ready), 128'(1));
        ls_ack = 1'b1; ls_rdata = 128'hBAD;
        for (int j = 0; j < 3; j++) begin
            tick();
            check_val("late_ack_wb_en", 128'(wb_en), 128'(0));
            check_val("late_ack_req", 128'(ls_req), 128'(0));
            check_val("late_ack_ready", 128'(ex_ready), 128'(1));
        end
        ls_ack = 1'b0;

        // Reset while an ALU writeback is on the port
        ex_valid = 1'b1; ex_alu_result = 128'h99; ex_dest_reg = 7'd2;
        ex_reg_write = 1; ex_mem_read = 0; ex_mem_write = 0;
        tick();
        check_val("rstwb_wb_en_before", 128'(wb_en), 128'(1));
        ex_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rstwb_wb_en", 128'(wb_en), 128'(0));
        check_val("rstwb_ready", 128'(ex_ready), 128'(1));
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
